// File: rtl/uart_tx_drain_if.sv
// FIFO-drain and serial-line signals of uart_tx_drain, bundled as one interface.
// The master modport is the transmitter side and the slave modport is the FIFO/line side.
interface uart_tx_drain_if #(
  parameter int c_DATAWIDTH = 8
);
  logic                   i_fifo_empty;
  logic [c_DATAWIDTH-1:0] i_fifo_data;
  logic                   o_fifo_readen;
  logic                   o_tx;
  logic                   o_busy;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_data,
    output o_fifo_readen,
    output o_tx,
    output o_busy
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_data,
    input  o_fifo_readen,
    input  o_tx,
    input  o_busy
  );
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops characters from an upstream FIFO and serialises them.
// Frame: start, c_DATAWIDTH data bits LSB first, optional parity, stop.
module uart_tx_drain #(
  parameter int c_CLKS_PER_BIT = 104,
  parameter int c_DATAWIDTH    = 8,
  parameter int c_PARITY       = 0
) (
  input  logic           i_clock,
  input  logic           i_reset,
  uart_tx_drain_if.master bus
);

  localparam int CNT_W = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
  localparam int IDX_W = (c_DATAWIDTH > 1) ? $clog2(c_DATAWIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(c_DATAWIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic             HAS_PARITY = (c_PARITY != 0) ? 1'b1 : 1'b0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [c_DATAWIDTH-1:0] data, input int mode);
    logic even;
    even = ^data;
    parity_bit = (mode == 2) ? ~even : even;
  endfunction

  logic [2:0]             state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [IDX_W-1:0]       idx_r;
  logic [c_DATAWIDTH-1:0] shift_r;
  logic                   parity_r;
  logic                   tx_r;
  logic                   busy_r;
  logic                   armed_r;

  logic [2:0]             state_s;
  logic [CNT_W-1:0]       cnt_s;
  logic [IDX_W-1:0]       idx_s;
  logic [c_DATAWIDTH-1:0] shift_s;
  logic [c_DATAWIDTH-1:0] shift_next_s;
  logic                   parity_s;
  logic                   tx_s;
  logic                   busy_s;
  logic                   pop_s;
  logic                   bit_end_s;

  // Pop strobe and bit-boundary decode; armed_r holds off the pop until a full cycle out of reset.
  always_comb begin
    pop_s        = (state_r == ST_IDLE) && armed_r && !i_reset && !bus.i_fifo_empty;
    bit_end_s    = (cnt_r == CNT_LAST);
    shift_next_s = shift_r >> 1;
  end

  // Next-state logic; tx_s is the line level for the cycle after the edge, so o_tx stays registered.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    shift_s  = shift_r;
    parity_s = parity_r;
    tx_s     = tx_r;
    busy_s   = busy_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        idx_s = IDX_ZERO;
        if (pop_s) begin
          state_s  = ST_START;
          shift_s  = bus.i_fifo_data;
          parity_s = parity_bit(bus.i_fifo_data, c_PARITY);
          tx_s     = 1'b0;
          busy_s   = 1'b1;
        end else begin
          state_s  = ST_IDLE;
          tx_s     = 1'b1;
          busy_s   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
          cnt_s   = CNT_ZERO;
          tx_s    = shift_r[0];
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_s = CNT_ZERO;
          if (idx_r == IDX_LAST) begin
            idx_s = IDX_ZERO;
            if (HAS_PARITY) begin
              state_s = ST_PARITY;
              tx_s    = parity_r;
            end else begin
              state_s = ST_STOP;
              tx_s    = 1'b1;
            end
          end else begin
            idx_s   = idx_r + IDX_ONE;
            shift_s = shift_next_s;
            tx_s    = shift_next_s[0];
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_s = ST_STOP;
          cnt_s   = CNT_ZERO;
          tx_s    = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          tx_s    = 1'b1;
          busy_s  = 1'b0;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        cnt_s    = CNT_ZERO;
        idx_s    = IDX_ZERO;
        shift_s  = {c_DATAWIDTH{1'b0}};
        parity_s = 1'b0;
        tx_s     = 1'b1;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State registers; reset forces the line idle-high at once and drops any frame in flight.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      idx_r    <= IDX_ZERO;
      shift_r  <= {c_DATAWIDTH{1'b0}};
      parity_r <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      armed_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      parity_r <= parity_s;
      tx_r     <= tx_s;
      busy_r   <= busy_s;
      armed_r  <= 1'b1;
    end
  end

  assign bus.o_fifo_readen = pop_s;
  assign bus.o_tx          = tx_r;
  assign bus.o_busy        = busy_r;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain: three instances (no/even/odd parity), 4 clocks per bit.
module tb_uart_tx_drain;
  localparam int C = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   pops [3] = '{0, 0, 0};
  int   last_pop [3] = '{0, 0, 0};
  int   prev_pop [3] = '{0, 0, 0};

  logic [7:0] fq0 [$];
  logic [7:0] fq1 [$];
  logic [7:0] fq2 [$];
  logic [7:0] exp_d [$];
  logic       exp_p [$];
  int         exp_busy [$];

  always #5 clk = ~clk;

  uart_tx_drain_if #(.c_DATAWIDTH(W)) bus0 ();
  uart_tx_drain_if #(.c_DATAWIDTH(W)) bus1 ();
  uart_tx_drain_if #(.c_DATAWIDTH(W)) bus2 ();

  uart_tx_drain #(.c_CLKS_PER_BIT(C), .c_DATAWIDTH(W), .c_PARITY(0)) u0 (
    .i_clock(clk), .i_reset(rst), .bus(bus0.master));
  uart_tx_drain #(.c_CLKS_PER_BIT(C), .c_DATAWIDTH(W), .c_PARITY(1)) u1 (
    .i_clock(clk), .i_reset(rst), .bus(bus1.master));
  uart_tx_drain #(.c_CLKS_PER_BIT(C), .c_DATAWIDTH(W), .c_PARITY(2)) u2 (
    .i_clock(clk), .i_reset(rst), .bus(bus2.master));

  wire tx_w [3];
  wire busy_w [3];
  wire rd_w [3];
  assign tx_w[0] = bus0.o_tx;   assign busy_w[0] = bus0.o_busy; assign rd_w[0] = bus0.o_fifo_readen;
  assign tx_w[1] = bus1.o_tx;   assign busy_w[1] = bus1.o_busy; assign rd_w[1] = bus1.o_fifo_readen;
  assign tx_w[2] = bus2.o_tx;   assign busy_w[2] = bus2.o_busy; assign rd_w[2] = bus2.o_fifo_readen;

  // FIFO models: pop on the strobe at the rising edge, log pop times.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (rd_w[k] === 1'b1) begin
        pops[k]     <= pops[k] + 1;
        prev_pop[k] <= last_pop[k];
        last_pop[k] <= cyc;
      end
    end
    if (bus0.o_fifo_readen === 1'b1 && fq0.size() > 0) void'(fq0.pop_front());
    if (bus1.o_fifo_readen === 1'b1 && fq1.size() > 0) void'(fq1.pop_front());
    if (bus2.o_fifo_readen === 1'b1 && fq2.size() > 0) void'(fq2.pop_front());
  end

  // FIFO head/empty presented on the falling edge.
  always @(negedge clk) begin
    bus0.i_fifo_empty <= (fq0.size() == 0);
    bus0.i_fifo_data  <= (fq0.size() > 0) ? fq0[0] : 8'h00;
    bus1.i_fifo_empty <= (fq1.size() == 0);
    bus1.i_fifo_data  <= (fq1.size() > 0) ? fq1[0] : 8'h00;
    bus2.i_fifo_empty <= (fq2.size() == 0);
    bus2.i_fifo_data  <= (fq2.size() > 0) ? fq2[0] : 8'h00;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input int k, input logic [7:0] d);
    case (k)
      0: fq0.push_back(d);
      1: fq1.push_back(d);
      default: fq2.push_back(d);
    endcase
    exp_d.push_back(d);
    exp_p.push_back((k == 1) ? ^d : ((k == 2) ? ~(^d) : 1'b0));
    exp_busy.push_back((2 + W + ((k != 0) ? 1 : 0)) * C);
  endtask

  // Monitor: waits for a start bit, samples every cycle of the frame and the idle cycle after it.
  task automatic get_frame(input int k, output logic [7:0] d, output logic p, output int busy_n,
                           output bit ok, output int waited, output int start_cyc);
    bit   glitch;
    logic b;
    int   nb;
    glitch = 1'b0; ok = 1'b0; waited = 0; d = 8'h00; p = 1'b0; busy_n = 0; start_cyc = 0; b = 1'b0;
    nb = W + 2 + ((k != 0) ? 1 : 0);
    @(negedge clk);
    while (tx_w[k] !== 1'b0 && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 300) return;
    start_cyc = cyc;
    for (int s = 0; s < nb; s++) begin
      for (int j = 0; j < C; j++) begin
        if (j == 0) b = tx_w[k];
        else if (tx_w[k] !== b) glitch = 1'b1;
        if (busy_w[k] === 1'b1) busy_n++;
        @(negedge clk);
      end
      if (s == 0 && b !== 1'b0) glitch = 1'b1;
      else if (s >= 1 && s <= W) d[s-1] = b;
      else if (s == W + 1 && k != 0) p = b;
      if (s == nb - 1 && b !== 1'b1) glitch = 1'b1;
    end
    if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0) glitch = 1'b1;
    ok = !glitch;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b1;
    push(0, 8'hA5);
    repeat (3) begin
      @(negedge clk); #1;
      if (bus0.o_fifo_readen !== 1'b0 || bus0.o_tx !== 1'b1 || bus0.o_busy !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL reset_hold: %0d bad samples, want 0", bad); else pass_cnt++;
    total_cnt++;
    if (bus0.o_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus0.o_tx); else pass_cnt++;
    total_cnt++;
    if (bus0.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus0.o_busy); else pass_cnt++;
    total_cnt++;
    if (bus1.o_tx !== 1'b1 || bus2.o_tx !== 1'b1)
      $display("FAIL reset_tx_par: got %b%b want 11", bus1.o_tx, bus2.o_tx); else pass_cnt++;
    total_cnt++;
    if (pops[0] !== 0) $display("FAIL reset_pops: got %0d want 0", pops[0]); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus0.o_fifo_readen !== 1'b0)
      $display("FAIL release_early_pop: got %b want 0", bus0.o_fifo_readen); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [7:0] d; logic p; int bn; bit ok; int w; int sc; int bad;
    logic [7:0] ed; int eb;
    get_frame(0, d, p, bn, ok, w, sc);
    ed = exp_d.pop_front(); void'(exp_p.pop_front()); eb = exp_busy.pop_front();
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL single_shape: frame malformed or missing"); else pass_cnt++;
    total_cnt++;
    if (d !== ed) $display("FAIL single_data: got %02h want %02h", d, ed); else pass_cnt++;
    total_cnt++;
    if (bn !== eb) $display("FAIL single_busy: got %0d want %0d", bn, eb); else pass_cnt++;
    bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (bus0.o_tx !== 1'b1 || bus0.o_fifo_readen !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL single_idle_after: %0d bad samples, want 0", bad); else pass_cnt++;
    total_cnt++;
    if (pops[0] !== 1) $display("FAIL single_pops: got %0d want 1", pops[0]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2; logic p; int b1, b2; bit ok1, ok2; int w1, w2; int s1, s2;
    logic [7:0] e1, e2;
    push(0, 8'h00);
    push(0, 8'hFF);
    get_frame(0, d1, p, b1, ok1, w1, s1);
    get_frame(0, d2, p, b2, ok2, w2, s2);
    e1 = exp_d.pop_front(); void'(exp_p.pop_front()); void'(exp_busy.pop_front());
    e2 = exp_d.pop_front(); void'(exp_p.pop_front()); void'(exp_busy.pop_front());
    total_cnt++;
    if (ok1 !== 1'b1 || ok2 !== 1'b1) $display("FAIL b2b_shape: ok %b %b want 1 1", ok1, ok2); else pass_cnt++;
    total_cnt++;
    if (d1 !== e1) $display("FAIL b2b_data1: got %02h want %02h", d1, e1); else pass_cnt++;
    total_cnt++;
    if (d2 !== e2) $display("FAIL b2b_data2: got %02h want %02h", d2, e2); else pass_cnt++;
    total_cnt++;
    if (s2 - s1 !== 41) $display("FAIL b2b_start_gap: got %0d want 41", s2 - s1); else pass_cnt++;
    total_cnt++;
    if (w2 !== 0) $display("FAIL b2b_idle_cycles: got %0d extra want 0", w2); else pass_cnt++;
    total_cnt++;
    if (last_pop[0] - prev_pop[0] !== 41)
      $display("FAIL b2b_pop_gap: got %0d want 41", last_pop[0] - prev_pop[0]); else pass_cnt++;
  endtask

  task automatic test_parity();
    logic [7:0] d; logic p; int bn; bit ok; int w; int sc;
    logic [7:0] ed; logic ep; int eb;
    for (int k = 1; k <= 2; k++) begin
      push(k, 8'h07);
      get_frame(k, d, p, bn, ok, w, sc);
      ed = exp_d.pop_front(); ep = exp_p.pop_front(); eb = exp_busy.pop_front();
      total_cnt++;
      if (ok !== 1'b1 || d !== ed) $display("FAIL parity%0d_data: got %02h ok %b want %02h", k, d, ok, ed); else pass_cnt++;
      total_cnt++;
      if (p !== ep) $display("FAIL parity%0d_bit: got %b want %b", k, p, ep); else pass_cnt++;
      total_cnt++;
      if (bn !== eb) $display("FAIL parity%0d_busy: got %0d want %0d", k, bn, eb); else pass_cnt++;
    end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] d; logic p; int bn; bit ok; int w; int sc; int n; int bad; int p0;
    logic [7:0] ed;
    push(0, 8'h55);
    n = 0;
    @(negedge clk);
    while (bus0.o_tx !== 1'b0 && n < 300) begin n++; @(negedge clk); end
    total_cnt++;
    if (n >= 300) $display("FAIL midrst_start: no start bit seen"); else pass_cnt++;
    repeat (17) @(negedge clk);
    #1;
    total_cnt++;
    if (bus0.o_tx !== 1'b0 || bus0.o_busy !== 1'b1)
      $display("FAIL midrst_bit3: tx %b busy %b want 0 1", bus0.o_tx, bus0.o_busy); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (bus0.o_tx !== 1'b1 || bus0.o_busy !== 1'b0)
      $display("FAIL midrst_async: tx %b busy %b want 1 0", bus0.o_tx, bus0.o_busy); else pass_cnt++;
    void'(exp_d.pop_front()); void'(exp_p.pop_front()); void'(exp_busy.pop_front());
    p0 = pops[0];
    push(0, 8'h3C);
    bad = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (bus0.o_fifo_readen !== 1'b0 || bus0.o_tx !== 1'b1) bad++;
    end
    total_cnt++;
    if (bad !== 0 || pops[0] !== p0)
      $display("FAIL midrst_hold: %0d bad samples, pops %0d want %0d", bad, pops[0], p0); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus0.o_fifo_readen !== 1'b0)
      $display("FAIL midrst_release_pop: got %b want 0", bus0.o_fifo_readen); else pass_cnt++;
    get_frame(0, d, p, bn, ok, w, sc);
    ed = exp_d.pop_front(); void'(exp_p.pop_front()); void'(exp_busy.pop_front());
    total_cnt++;
    if (ok !== 1'b1 || d !== ed) $display("FAIL midrst_next: got %02h ok %b want %02h", d, ok, ed); else pass_cnt++;
  endtask

  task automatic test_empty_holdoff();
    logic [7:0] d; logic p; int bn; bit ok; int w; int sc; int bad; int p0;
    logic [7:0] ed;
    bad = 0;
    p0 = pops[0];
    repeat (100) begin
      @(negedge clk); #1;
      if (bus0.o_fifo_readen !== 1'b0 || bus0.o_tx !== 1'b1) bad++;
    end
    total_cnt++;
    if (bad !== 0 || pops[0] !== p0)
      $display("FAIL holdoff_quiet: %0d bad samples, pops %0d want %0d", bad, pops[0], p0); else pass_cnt++;
    push(0, 8'h5A);
    @(negedge clk); #1;
    total_cnt++;
    if (bus0.o_fifo_readen !== 1'b1)
      $display("FAIL holdoff_readen: got %b want 1", bus0.o_fifo_readen); else pass_cnt++;
    get_frame(0, d, p, bn, ok, w, sc);
    ed = exp_d.pop_front(); void'(exp_p.pop_front()); void'(exp_busy.pop_front());
    total_cnt++;
    if (w !== 0) $display("FAIL holdoff_start_delay: got %0d extra cycles want 0", w); else pass_cnt++;
    total_cnt++;
    if (ok !== 1'b1 || d !== ed) $display("FAIL holdoff_data: got %02h ok %b want %02h", d, ok, ed); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_midframe_reset();
    test_empty_holdoff();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
